// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 16-byte lines.
// Hits complete in the request cycle; misses write back a dirty victim, then fill from pmem.
module l1_dcache #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_req,
  input  logic         mem_we,
  input  logic [15:0]  mem_addr,
  input  logic [15:0]  mem_byte_en,
  input  logic [127:0] mem_wdata,
  output logic         mem_resp,
  output logic [127:0] mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_addr,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = 12 - INDEX_BITS;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } state_t;

  state_t state, state_next;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   addr_tag;
  logic                  hit;
  logic                  write_hit;
  logic                  wb_done;
  logic                  fill_done;
  logic                  unused_offset;

  assign idx           = mem_addr[3+INDEX_BITS:4];
  assign addr_tag      = mem_addr[15:4+INDEX_BITS];
  assign hit           = valid[idx] && (tag_q[idx] == addr_tag);
  assign write_hit     = (state == CHECK) && mem_req && hit && mem_we;
  assign wb_done       = (state == WRITEBACK) && pmem_resp;
  assign fill_done     = (state == FILL) && pmem_resp;
  // Whole lines are returned, so the byte offset never selects anything.
  assign unused_offset = ^mem_addr[3:0];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking (=) here would create order-dependent simulation/synthesis mismatches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CHECK;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      if (write_hit && (|mem_byte_en)) dirty[idx] <= 1'b1;
      if (wb_done) dirty[idx] <= 1'b0;
      if (fill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag/data arrays are deliberately left out of reset; valid=0 masks their contents,
  // and omitting reset lets them map onto plain storage instead of resettable flops.
  always_ff @(posedge clk) begin
    if (write_hit) begin
      for (int b = 0; b < 16; b++) begin
        if (mem_byte_en[b]) data_q[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (fill_done) begin
      data_q[idx] <= pmem_rdata;
      tag_q[idx]  <= addr_tag;
    end
  end

  // NOTE: every output is given a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    mem_resp   = 1'b0;
    mem_rdata  = '0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    unique case (state)
      CHECK: begin
        if (mem_req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            mem_rdata = data_q[idx];
          end else if (valid[idx] && dirty[idx]) begin
            state_next = WRITEBACK;
          end else begin
            state_next = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_addr  = {tag_q[idx], idx, 4'h0};
        pmem_wdata = data_q[idx];
        // An abandoned request still finishes the writeback but skips the fill.
        if (pmem_resp) state_next = mem_req ? FILL : CHECK;
      end
      FILL: begin
        pmem_read = 1'b1;
        pmem_addr = {mem_addr[15:4], 4'h0};
        if (pmem_resp) state_next = CHECK;
      end
      default: state_next = CHECK;
    endcase
  end

endmodule
